ccip_c0_rd_arbiter: RTL and testbench
=====================================

// Module: ccip_c0_rd_arbiter
// PURPOSE
//  Shares the CCI-P C0 read-request channel between NUM_REQ AFU-side requesters, placed between AFU engines and pck_af2cp_sTx.c0.
//  Round-robin grants, gated by c0TxAlmFull and a per-requester outstanding limit.
//  Requester id is encoded into mdata; C0 read responses are routed back to the issuing requester.
//  A drain FSM quiesces the channel before soft reconfiguration.
// PARAMETERS
//  NUM_REQ   4   requesters, 2..16
//  ADDR_W    42  cache-line address width
//  TAG_W     8   requester tag width, <=12
//  MAX_OUT   32  outstanding reads per requester, 1..255
// PORTS
//  pClk                    in   1              CCI-P primary clock
//  pck_cp2af_softReset_n   in   1              synchronous active-low reset
//  req_valid               in   NUM_REQ        read request per requester
//  req_addr                in   NUM_REQ*ADDR_W line address, slice i for requester i
//  req_tag                 in   NUM_REQ*TAG_W  requester tag, slice i
//  req_ready               out  NUM_REQ        one-hot grant; transfer = valid&ready
//  c0tx_valid              out  1              C0 TX read request valid
//  c0tx_addr               out  ADDR_W         C0 TX address
//  c0tx_mdata              out  16             {id[3:0], 0.., tag}
//  c0TxAlmFull             in   1              C0 TX almost-full from the CCI-P emulator
//  c0rx_rspValid           in   1              C0 RX read response valid
//  c0rx_mdata              in   16             mdata returned with the response
//  c0rx_data               in   512            response data
//  rsp_valid               out  NUM_REQ        one-hot routed response
//  rsp_tag                 out  TAG_W          tag of the routed response
//  rsp_data                out  512            routed response data
//  drain_req               in   1              request quiesce, level
//  drain_done              out  1              no grants and zero outstanding
//  err_bad_rsp             out  1              sticky: response with id>=NUM_REQ or with count 0
// BEHAVIOUR
//  Reset (softReset_n=0 at a pClk edge):
//   - all outputs 0; all outstanding counters 0; RR pointer 0; FSM RUN.
//   - Clears mid-operation state without draining.
//  Eligibility: requester i is eligible iff req_valid[i] && cnt[i]<MAX_OUT && state==RUN && !c0TxAlmFull.
//  Grant: combinational, first eligible at or after ptr (mod NUM_REQ).
//   - req_ready[i]=1 for that i only; req_ready may depend on req_valid.
//   - After a grant to i, ptr <= (i+1) mod NUM_REQ; with no grant, ptr holds.
//  Request pipeline, 1-cycle latency:
//   - the cycle after grant to i: c0tx_valid=1, c0tx_addr=req_addr[i], c0tx_mdata[15:12]=i, [TAG_W-1:0]=tag, other bits 0.
//   - otherwise c0tx_valid=0, addr/mdata hold.
//  Response pipeline, 1-cycle latency; id=c0rx_mdata[15:12]:
//   - if id<NUM_REQ and cnt[id]>0: rsp_valid[id]=1, rsp_tag=c0rx_mdata[TAG_W-1:0], rsp_data=c0rx_data, cnt[id]-1.
//   - if id>=NUM_REQ or cnt[id]==0: response dropped, err_bad_rsp<=1, counter unchanged (no underflow).
//  Counters:
//   - grant and response for the same i in the same cycle -> cnt[i] unchanged.
//   - cnt never exceeds MAX_OUT (eligibility gate).
//  FSM:
//   - RUN   -> DRAIN when drain_req=1 (no grants from that cycle).
//   - DRAIN -> IDLE when all cnt==0 and c0tx_valid==0.
//   - IDLE  : drain_done=1 (registered); -> RUN when drain_req=0, drain_done falls same edge.
//   - Responses are still routed in DRAIN and IDLE.
//  c0TxAlmFull is used combinationally; a request already in the output register still issues.
//   This uses CCI-P almost-full slack; at most 1 request follows assertion.
// TESTING
//  - Reset: hold softReset_n=0 3 cycles with req_valid=4'hF -> req_ready=0, c0tx_valid=0, drain_done=0.
//  - Round-robin: req_valid=4'hF, AlmFull=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3, c0tx_mdata[15:12] same order 1 cycle later.
//  - AlmFull: assert AlmFull with req_valid=4'h1 -> no req_ready from that cycle; deassert -> grant next cycle.
//  - Limit: MAX_OUT=2, req0 only, no responses -> exactly 2 grants.
//    Then one response with mdata=16'h0005 -> rsp_valid=4'b0001, rsp_tag=8'h05 one cycle later, third grant follows.
//  - Bad response: c0rx_mdata=16'hF000 with NUM_REQ=4 -> no rsp_valid, err_bad_rsp=1 and stays 1 until reset.
//  - Drain: 3 outstanding on req2, drain_req=1 -> req_ready stays 0.
//    drain_done rises 1 cycle after the 3rd response; drain_req=0 -> grants resume.

Source files
------------

// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P C0 read-request channel among NUM_REQ requesters.
// Tags requests with the requester id in mdata, routes responses back and drains on request.
module ccip_c0_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 42,
    parameter int TAG_W   = 8,
    parameter int MAX_OUT = 32
) (
    input  logic                      pClk,
    input  logic                      pck_cp2af_softReset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      c0tx_valid,
    output logic [ADDR_W-1:0]         c0tx_addr,
    output logic [15:0]               c0tx_mdata,
    input  logic                      c0TxAlmFull,
    input  logic                      c0rx_rspValid,
    input  logic [15:0]               c0rx_mdata,
    input  logic [511:0]              c0rx_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic [511:0]              rsp_data,
    input  logic                      drain_req,
    output logic                      drain_done,
    output logic                      err_bad_rsp
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_IDLE
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REQ];
    logic [CNT_W-1:0]    cnt_d [NUM_REQ];

    logic                c0tx_valid_q, c0tx_valid_d;
    logic [ADDR_W-1:0]   c0tx_addr_q, c0tx_addr_d;
    logic [15:0]         c0tx_mdata_q, c0tx_mdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic [511:0]        rsp_data_q, rsp_data_d;
    logic                drain_done_q, drain_done_d;
    logic                err_q, err_d;

    logic                run_ok;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_any;
    logic [PTR_W-1:0]    grant_id;

    logic [3:0]          rsp_id;
    logic [PTR_W-1:0]    rsp_idx;
    logic                rsp_id_ok;
    logic                rsp_hit;
    logic                rsp_bad;
    logic                all_zero;
    logic                unused_mdata;

    assign unused_mdata = ^c0rx_mdata;

    // Grants are held off during reset so req_ready reads 0 while softReset_n is low.
    assign run_ok = pck_cp2af_softReset_n && (state_q == ST_RUN) && !drain_req && !c0TxAlmFull;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = run_ok && req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && eligible[(int'(ptr_q) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_id  = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign ptr_d     = grant_any ? PTR_W'((int'(grant_id) + 1) % NUM_REQ) : ptr_q;

    always_comb begin
        c0tx_valid_d = grant_any;
        c0tx_addr_d  = c0tx_addr_q;
        c0tx_mdata_d = c0tx_mdata_q;
        if (grant_any) begin
            c0tx_addr_d              = req_addr[grant_id*ADDR_W +: ADDR_W];
            c0tx_mdata_d             = '0;
            c0tx_mdata_d[15:12]      = 4'(grant_id);
            c0tx_mdata_d[TAG_W-1:0]  = req_tag[grant_id*TAG_W +: TAG_W];
        end
    end

    // A response is only accepted against a live outstanding count; anything else is flagged.
    assign rsp_id    = c0rx_mdata[15:12];
    assign rsp_idx   = PTR_W'(rsp_id);
    assign rsp_id_ok = int'(rsp_id) < NUM_REQ;
    assign rsp_hit   = c0rx_rspValid && rsp_id_ok && (cnt_q[rsp_idx] != '0);
    assign rsp_bad   = c0rx_rspValid && !rsp_hit;

    always_comb begin
        rsp_valid_d = '0;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q | rsp_bad;
        if (rsp_hit) begin
            rsp_valid_d[rsp_idx] = 1'b1;
            rsp_tag_d            = c0rx_mdata[TAG_W-1:0];
            rsp_data_d           = c0rx_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !(rsp_hit && (rsp_idx == PTR_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!grant[i] && rsp_hit && (rsp_idx == PTR_W'(i))) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_q[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req)                     state_d = ST_DRAIN;
            ST_DRAIN: if (all_zero && !c0tx_valid_q)     state_d = ST_IDLE;
            ST_IDLE:  if (!drain_req)                    state_d = ST_RUN;
            default:                                     state_d = ST_RUN;
        endcase
        drain_done_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            state_q      <= ST_RUN;
            ptr_q        <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            c0tx_valid_q <= 1'b0;
            c0tx_addr_q  <= '0;
            c0tx_mdata_q <= '0;
            rsp_valid_q  <= '0;
            rsp_tag_q    <= '0;
            rsp_data_q   <= '0;
            drain_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            c0tx_valid_q <= c0tx_valid_d;
            c0tx_addr_q  <= c0tx_addr_d;
            c0tx_mdata_q <= c0tx_mdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_data_q   <= rsp_data_d;
            drain_done_q <= drain_done_d;
            err_q        <= err_d;
        end
    end

    assign c0tx_valid  = c0tx_valid_q;
    assign c0tx_addr   = c0tx_addr_q;
    assign c0tx_mdata  = c0tx_mdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_data    = rsp_data_q;
    assign drain_done  = drain_done_q;
    assign err_bad_rsp = err_q;

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Scoreboard bench for ccip_c0_rd_arbiter: a cycle model predicts grants and responses,
// plus a second instance with MAX_OUT=2 for the outstanding-limit scenario.
module tb_ccip_c0_rd_arbiter;

    localparam int NR = 4;
    localparam int AW = 42;
    localparam int TW = 8;
    localparam int MO = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NR-1:0]       req_valid;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*TW-1:0]    req_tag;
    logic [NR-1:0]       req_ready;
    logic                c0tx_valid;
    logic [AW-1:0]       c0tx_addr;
    logic [15:0]         c0tx_mdata;
    logic                alm;
    logic                rspv;
    logic [15:0]         rmd;
    logic [511:0]        rdata;
    logic [NR-1:0]       rsp_valid;
    logic [TW-1:0]       rsp_tag;
    logic [511:0]        rsp_data;
    logic                drain_req;
    logic                drain_done;
    logic                err;

    logic [NR-1:0]       b_req_valid;
    logic [NR-1:0]       b_req_ready;
    logic                b_c0tx_valid;
    logic [AW-1:0]       b_c0tx_addr;
    logic [15:0]         b_c0tx_mdata;
    logic                b_alm;
    logic                b_rspv;
    logic [15:0]         b_mdata;
    logic [NR-1:0]       b_rsp_valid;
    logic [TW-1:0]       b_rsp_tag;
    logic [511:0]        b_rsp_data;
    logic                b_drain_req;
    logic                b_drain_done;
    logic                b_err;

    ccip_c0_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TAG_W(TW), .MAX_OUT(MO)) dut (
        .pClk(clk), .pck_cp2af_softReset_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
        .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata),
        .c0TxAlmFull(alm), .c0rx_rspValid(rspv), .c0rx_mdata(rmd), .c0rx_data(rdata),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .drain_req(drain_req), .drain_done(drain_done), .err_bad_rsp(err)
    );

    ccip_c0_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TAG_W(TW), .MAX_OUT(2)) dut_lim (
        .pClk(clk), .pck_cp2af_softReset_n(rst_n),
        .req_valid(b_req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(b_req_ready),
        .c0tx_valid(b_c0tx_valid), .c0tx_addr(b_c0tx_addr), .c0tx_mdata(b_c0tx_mdata),
        .c0TxAlmFull(b_alm), .c0rx_rspValid(b_rspv), .c0rx_mdata(b_mdata), .c0rx_data(rdata),
        .rsp_valid(b_rsp_valid), .rsp_tag(b_rsp_tag), .rsp_data(b_rsp_data),
        .drain_req(b_drain_req), .drain_done(b_drain_done), .err_bad_rsp(b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef enum int {M_RUN, M_DRAIN, M_IDLE} mst_e;

    mst_e              m_state = M_RUN;
    mst_e              m_next;
    int                m_ptr = 0;
    int                m_cnt [NR] = '{default: 0};
    bit                m_c0v = 1'b0;
    logic [NR-1:0]     m_rspv = '0;
    bit                m_err = 1'b0;
    logic [AW+15:0]    q_tx  [$];
    logic [TW+511:0]   q_rsp [$];
    bit                mon_en = 1'b0;
    bit                rec_en = 1'b0;
    int                obs_g  [$];
    int                obs_id [$];

    int                gid;
    int                rid;
    bit                all0;
    logic [NR-1:0]     exp_rdy;
    logic [AW+15:0]    tx_e;
    logic [TW+511:0]   rs_e;

    always @(negedge clk) begin
        if (mon_en) begin
            check("c0tx_valid", 512'(c0tx_valid), 512'(m_c0v));
            if (c0tx_valid && m_c0v) begin
                if (q_tx.size() == 0) begin
                    check("tx_queue_size", 512'(q_tx.size()), 512'(1));
                end else begin
                    tx_e = q_tx.pop_front();
                    check("c0tx_addr", 512'(c0tx_addr), 512'(tx_e[AW+15:16]));
                    check("c0tx_mdata", 512'(c0tx_mdata), 512'(tx_e[15:0]));
                end
                if (rec_en) obs_id.push_back(int'(c0tx_mdata[15:12]));
            end
            check("rsp_valid", 512'(rsp_valid), 512'(m_rspv));
            if (m_rspv != '0 && rsp_valid == m_rspv) begin
                if (q_rsp.size() == 0) begin
                    check("rsp_queue_size", 512'(q_rsp.size()), 512'(1));
                end else begin
                    rs_e = q_rsp.pop_front();
                    check("rsp_tag", 512'(rsp_tag), 512'(rs_e[TW+511:512]));
                    check("rsp_data", rsp_data, rs_e[511:0]);
                end
            end
            check("err_bad_rsp", 512'(err), 512'(m_err));
            check("drain_done", 512'(drain_done), 512'(m_state == M_IDLE));

            exp_rdy = '0;
            gid = -1;
            if (rst_n && m_state == M_RUN && !drain_req && !alm) begin
                for (int k = 0; k < NR; k++) begin
                    if (gid < 0 && req_valid[(m_ptr + k) % NR] && m_cnt[(m_ptr + k) % NR] < MO)
                        gid = (m_ptr + k) % NR;
                end
            end
            if (gid >= 0) exp_rdy[gid] = 1'b1;
            check("req_ready", 512'(req_ready), 512'(exp_rdy));
            if (rec_en) begin
                for (int i = 0; i < NR; i++) if (req_ready[i]) obs_g.push_back(i);
            end

            if (!rst_n) begin
                m_state = M_RUN;
                m_ptr   = 0;
                for (int i = 0; i < NR; i++) m_cnt[i] = 0;
                m_c0v   = 1'b0;
                m_rspv  = '0;
                m_err   = 1'b0;
                q_tx.delete();
                q_rsp.delete();
            end else begin
                all0 = 1'b1;
                for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) all0 = 1'b0;
                m_next = m_state;
                case (m_state)
                    M_RUN:   if (drain_req)        m_next = M_DRAIN;
                    M_DRAIN: if (all0 && !m_c0v)   m_next = M_IDLE;
                    default: if (!drain_req)       m_next = M_RUN;
                endcase
                m_rspv = '0;
                if (rspv) begin
                    rid = int'(rmd[15:12]);
                    if (rid < NR && m_cnt[rid] > 0) begin
                        m_rspv[rid] = 1'b1;
                        m_cnt[rid]--;
                        q_rsp.push_back({rmd[TW-1:0], rdata});
                    end else begin
                        m_err = 1'b1;
                    end
                end
                m_c0v = (gid >= 0);
                if (gid >= 0) begin
                    q_tx.push_back({req_addr[gid*AW +: AW], 4'(gid), 4'h0, req_tag[gid*TW +: TW]});
                    m_cnt[gid]++;
                    m_ptr = (gid + 1) % NR;
                end
                m_state = m_next;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = AW'({$urandom, $urandom});
            req_tag[i*TW +: TW]  = TW'($urandom);
        end
    endtask

    task automatic rand_data();
        for (int w = 0; w < 16; w++) rdata[w*32 +: 32] = $urandom;
    endtask

    task automatic send_rsp(input int id, input logic [TW-1:0] tag);
        rspv = 1'b1;
        rmd  = {4'(id), 4'h0, tag};
        rand_data();
        tick();
        rspv = 1'b0;
    endtask

    int lim_cnt;
    int guard;

    initial begin
        rst_n = 1'b0; req_valid = 4'hF; alm = 1'b0; rspv = 1'b0; rmd = '0; rdata = '0;
        drain_req = 1'b0; req_addr = '0; req_tag = '0;
        b_req_valid = '0; b_alm = 1'b0; b_rspv = 1'b0; b_mdata = '0; b_drain_req = 1'b0;
        tick();
        mon_en = 1'b1;

        // reset held with all requesters valid
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", 512'(req_ready), 512'(4'h0));
            check("rst_c0tx_valid", 512'(c0tx_valid), 512'(1'b0));
            check("rst_drain_done", 512'(drain_done), 512'(1'b0));
            tick();
        end

        // round robin
        rst_n = 1'b1;
        rec_en = 1'b1;
        repeat (8) tick();
        req_valid = '0;
        tick();
        rec_en = 1'b0;
        check("rr_grant_count", 512'(obs_g.size()), 512'(8));
        check("rr_id_count", 512'(obs_id.size()), 512'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < obs_g.size())  check("rr_grant_order", 512'(obs_g[i]), 512'(i % NR));
            if (i < obs_id.size()) check("rr_mdata_id", 512'(obs_id[i]), 512'(i % NR));
        end

        // almost-full gating, with one request already registered
        req_valid = 4'h1;
        tick();
        alm = 1'b1;
        @(negedge clk);
        check("alm_inflight_issue", 512'(c0tx_valid), 512'(1'b1));
        repeat (3) begin
            @(negedge clk);
            check("alm_ready", 512'(req_ready), 512'(4'h0));
            tick();
        end
        alm = 1'b0;
        @(negedge clk);
        check("alm_release", 512'(req_ready), 512'(4'h1));
        tick();
        req_valid = '0;
        tick();

        // grant and response to the same requester in one cycle
        req_valid = 4'b0010;
        rspv = 1'b1; rmd = 16'h10A5; rand_data();
        @(negedge clk);
        check("simul_ready", 512'(req_ready), 512'(4'b0010));
        tick();
        rspv = 1'b0; req_valid = '0;
        tick();

        // return everything outstanding
        guard = 0;
        for (int id = 0; id < NR; id++) begin
            while (m_cnt[id] > 0 && guard < 64) begin
                send_rsp(id, TW'($urandom));
                guard++;
            end
        end
        tick();
        tick();

        // response to a requester with nothing outstanding
        @(negedge clk);
        check("pre_err", 512'(err), 512'(1'b0));
        send_rsp(3, 8'h11);
        @(negedge clk);
        check("cnt0_rsp_valid", 512'(rsp_valid), 512'(4'h0));
        check("cnt0_err", 512'(err), 512'(1'b1));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_err_clear", 512'(err), 512'(1'b0));
        tick();

        // out-of-range id
        rspv = 1'b1; rmd = 16'hF000; rand_data();
        tick();
        rspv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bad_rsp_valid", 512'(rsp_valid), 512'(4'h0));
            check("bad_err_sticky", 512'(err), 512'(1'b1));
            tick();
        end

        // outstanding limit on the MAX_OUT=2 instance
        b_req_valid = 4'h1;
        lim_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (b_req_ready[0]) lim_cnt++;
            tick();
        end
        check("lim_grants", 512'(lim_cnt), 512'(2));
        b_rspv = 1'b1; b_mdata = 16'h0005; rand_data();
        @(negedge clk);
        check("lim_full", 512'(b_req_ready), 512'(4'h0));
        tick();
        b_rspv = 1'b0;
        @(negedge clk);
        check("lim_rsp_valid", 512'(b_rsp_valid), 512'(4'b0001));
        check("lim_rsp_tag", 512'(b_rsp_tag), 512'(8'h05));
        check("lim_third_grant", 512'(b_req_ready), 512'(4'b0001));
        tick();
        b_req_valid = '0;
        tick();

        // drain with three outstanding on requester 2
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid = 4'hF;
        drain_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("drain_ready", 512'(req_ready), 512'(4'h0));
            check("drain_busy", 512'(drain_done), 512'(1'b0));
            tick();
        end
        for (int r = 0; r < 3; r++) begin
            send_rsp(2, TW'(r + 1));
            if (r < 2) tick();
        end
        @(negedge clk);
        check("drain_last_rsp", 512'(rsp_valid), 512'(4'b0100));
        check("drain_done_early", 512'(drain_done), 512'(1'b0));
        tick();
        @(negedge clk);
        check("drain_done_rise", 512'(drain_done), 512'(1'b1));
        check("drain_idle_ready", 512'(req_ready), 512'(4'h0));
        tick();
        drain_req = 1'b0;
        @(negedge clk);
        check("idle_done_hold", 512'(drain_done), 512'(1'b1));
        tick();
        @(negedge clk);
        check("resume_done_fall", 512'(drain_done), 512'(1'b0));
        check("resume_grant", 512'(req_ready != '0), 512'(1'b1));
        tick();
        req_valid = '0;
        repeat (2) tick();

        // final reset clears the sticky error
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("final_err_clear", 512'(err), 512'(1'b0));
        tick();
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
